// File: rtl/counter_pkg.sv
// Shared constants and helpers for the variable up/down counter family.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_safe(input int value);
    int w;
    w = 1;
    while ((32'sd1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides count enables by PRESCALE: step fires on every PRESCALE-th enabled cycle.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic sclr,
  output logic step
);

  localparam int PW = clog2_safe(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] phase_r;
  logic [PW-1:0] phase_nxt_s;
  logic          at_last_s;

  assign at_last_s = (phase_r == LAST);
  assign step      = ena & at_last_s;

  // Next phase: clear wins, a disabled cycle freezes the phase.
  always_comb begin
    phase_nxt_s = phase_r;
    if (sclr) begin
      phase_nxt_s = '0;
    end else if (ena) begin
      if (at_last_s) begin
        phase_nxt_s = '0;
      end else begin
        phase_nxt_s = phase_r + ONE;
      end
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r <= '0;
    end else begin
      phase_r <= phase_nxt_s;
    end
  end

endmodule

// File: rtl/counter_var_updown.sv
// Up/down counter with runtime modulo, clear, load and a registered wrap pulse.
// Optional prescaler on the count enable when COUNTER_VAR_PRESCALE_EN is defined.
module counter_var_updown
  import counter_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_ena,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulo,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             wrap_r;
  logic             wrap_nxt_s;
  logic             step_s;

`ifdef COUNTER_VAR_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .ena   (cnt_ena),
    .sclr  (clear | load),
    .step  (step_s)
  );
`else
  logic unused_prescale_s;
  assign unused_prescale_s = ^PRESCALE;
  assign step_s            = cnt_ena;
`endif

  // Next count and wrap flag: clear > load > step > hold.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    if (clear) begin
      count_nxt_s = '0;
    end else if (load) begin
      count_nxt_s = load_val;
    end else if (step_s) begin
      if (up_dn == DIR_UP) begin
        // Values above modulo (e.g. after a load) wrap on the next up step.
        if (count_r >= modulo) begin
          count_nxt_s = '0;
          wrap_nxt_s  = 1'b1;
        end else begin
          count_nxt_s = count_r + ONE;
        end
      end else begin
        if (count_r == '0) begin
          count_nxt_s = modulo;
          wrap_nxt_s  = 1'b1;
        end else begin
          count_nxt_s = count_r - ONE;
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count and wrap registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
    end
  end

  assign count = count_r;
  assign wrap  = wrap_r;
  assign tc    = ((up_dn == DIR_UP)   && (count_r >= modulo)) ||
                 ((up_dn == DIR_DOWN) && (count_r == '0));

endmodule

// File: tb/tb_counter_var_updown.sv
// Self-checking bench for counter_var_updown (WIDTH=4, PRESCALE=4).
module tb_counter_var_updown;

  localparam int W  = 4;
  localparam int PS = 4;

  logic         clk;
  logic         reset;
  logic         cnt_ena;
  logic         up_dn;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] modulo;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;

  int vectors;
  int miscompares;

  // Reference state kept as plain integers.
  int m_count;
  int m_wrap;
  int m_phase;

  typedef struct {
    bit c; bit l; int lv; bit e; bit u; int m;
    int exp_count; int exp_wrap; int exp_tc;
  } vec_t;

  vec_t tbl[$];

  counter_var_updown #(.WIDTH(W), .PRESCALE(PS)) dut (
    .clk      (clk),
    .reset    (reset),
    .cnt_ena  (cnt_ena),
    .up_dn    (up_dn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .modulo   (modulo),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    vectors = vectors + 1;
    if (got != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_tc(input bit u, input int m, input int c);
    if (u) return (c >= m) ? 1 : 0;
    return (c == 0) ? 1 : 0;
  endfunction

  // Advance the reference model by one clock edge with the given inputs.
  task automatic model_edge(input bit c, input bit l, input int lv, input bit e, input bit u, input int m);
    bit stp;
    if (c) begin
      m_count = 0; m_phase = 0; m_wrap = 0;
    end else if (l) begin
      m_count = lv; m_phase = 0; m_wrap = 0;
    end else begin
      stp = e;
`ifdef COUNTER_VAR_PRESCALE_EN
      if (e) begin
        stp = (m_phase == PS - 1);
        m_phase = (m_phase + 1) % PS;
      end
`endif
      m_wrap = 0;
      if (stp) begin
        if (u) begin
          if (m_count >= m) begin m_count = 0; m_wrap = 1; end
          else m_count = m_count + 1;
        end else begin
          if (m_count == 0) begin m_count = m; m_wrap = 1; end
          else m_count = m_count - 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, and compare DUT against the model.
  task automatic apply(input bit c, input bit l, input int lv, input bit e, input bit u, input int m);
    clear = c; load = l; load_val = W'(lv); cnt_ena = e; up_dn = u; modulo = W'(m);
    model_edge(c, l, lv, e, u, m);
    @(posedge clk);
    #1;
    check("model_count", int'(count), m_count);
    check("model_wrap", int'(wrap), m_wrap);
    check("model_tc", int'(tc), model_tc(u, m, m_count));
  endtask

  function automatic vec_t mk(bit c, bit l, int lv, bit e, bit u, int m, int ec, int ew, int et);
    vec_t v;
    v.c = c; v.l = l; v.lv = lv; v.e = e; v.u = u; v.m = m;
    v.exp_count = ec; v.exp_wrap = ew; v.exp_tc = et;
    return v;
  endfunction

  initial begin
    bit r_u;
    int r_m;
    vectors = 0; miscompares = 0;
    m_count = 0; m_wrap = 0; m_phase = 0;

    // Up count to modulo 9 and wrap
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(0, 0, 0, 1, 1, 9, i, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 9, 9, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 9, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 9, 1, 0, 0));
    // Down count, modulo 5
    tbl.push_back(mk(0, 0, 0, 1, 0, 5, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 5, 5, 1, 0));
    for (int i = 4; i >= 1; i--) tbl.push_back(mk(0, 0, 0, 1, 0, 5, i, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 5, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 5, 5, 1, 0));
    // Priority
    tbl.push_back(mk(1, 1, 7, 0, 1, 9, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 0, 1, 9, 7, 0, 0));
    tbl.push_back(mk(0, 1, 7, 1, 1, 9, 7, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 9, 8, 0, 0));
    // Load above modulo, then up step wraps
    tbl.push_back(mk(0, 1, 12, 0, 1, 9, 12, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 9, 0, 1, 0));
    // modulo = 0 wraps every step in both directions
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Load above modulo, down counts through it
    tbl.push_back(mk(0, 1, 12, 0, 0, 9, 12, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 9, 11, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 9, 10, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 9, 9, 0, 0));
    // Full-range modulo behaves as a binary counter
    tbl.push_back(mk(0, 1, 14, 0, 1, 15, 14, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 15, 15, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 15, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 15, 0, 0, 0));

    // Reset state
    reset = 1'b0; cnt_ena = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
    load_val = 4'd0; modulo = 4'd9;
    #12;
    check("reset_count", int'(count), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_tc", int'(tc), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].c, tbl[i].l, tbl[i].lv, tbl[i].e, tbl[i].u, tbl[i].m);
`ifndef COUNTER_VAR_PRESCALE_EN
      check($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_count);
      check($sformatf("tbl%0d_wrap", i), int'(wrap), tbl[i].exp_wrap);
      check($sformatf("tbl%0d_tc", i), int'(tc), tbl[i].exp_tc);
`endif
    end

    // Asynchronous reset mid-count
    apply(0, 1, 6, 0, 1, 9);
    check("pre_reset_count", int'(count), 6);
    cnt_ena = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_count", int'(count), 0);
    check("async_reset_wrap", int'(wrap), 0);
    m_count = 0; m_wrap = 0; m_phase = 0;
    @(posedge clk); #1;
    check("held_reset_count", int'(count), 0);
    reset = 1'b1;
    cnt_ena = 1'b0;

`ifdef COUNTER_VAR_PRESCALE_EN
    // Prescaler phase behaviour
    apply(0, 1, 0, 0, 1, 15);
    for (int i = 0; i < 12; i++) apply(0, 0, 0, 1, 1, 15);
    check("ps_12_count", int'(count), 3);
    apply(0, 0, 0, 1, 1, 15);
    apply(0, 0, 0, 1, 1, 15);
    apply(0, 0, 0, 0, 1, 15);
    apply(0, 0, 0, 0, 1, 15);
    apply(0, 0, 0, 1, 1, 15);
    check("ps_gap_hold", int'(count), 3);
    apply(0, 0, 0, 1, 1, 15);
    check("ps_gap_step", int'(count), 4);
    apply(0, 0, 0, 1, 1, 15);
    apply(0, 0, 0, 1, 1, 15);
    apply(0, 1, 0, 0, 1, 15);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 1, 1, 15);
    check("ps_load_phase_hold", int'(count), 0);
    apply(0, 0, 0, 1, 1, 15);
    check("ps_load_phase_step", int'(count), 1);
`endif

    // Randomized traffic against the model
    r_u = 1'b1; r_m = 9;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) r_u = ~r_u;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: r_m = 0;
          1: r_m = 15;
          default: r_m = int'($urandom_range(1, 14));
        endcase
      end
      apply($urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, r_u, r_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_var_updown.md
# counter_var_updown

Parametrised successor to the team's 16-bit enable counter. Adds:
- configurable width;
- a runtime modulo (wrap) value;
- up/down direction;
- synchronous clear and parallel load;
- a registered wrap pulse;
- an optional compile-time prescaler.

It sits wherever a free-running or event counter drives timebases or terminal-count triggers.

## Interface
- WIDTH, 16, counter width in bits (≥2)
- PRESCALE, 4, enabled cycles per count step when prescaler compiled in (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- cnt_ena  in  1  count enable, sampled each clk
- up_dn  in  1  1 = count up, 0 = count down
- clear  in  1  synchronous clear to 0
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value loaded when load=1
- modulo  in  WIDTH  terminal value; count range 0..modulo
- count  out  WIDTH  current count (registered)
- tc  out  1  terminal count (combinational from count, up_dn, modulo)
- wrap  out  1  one-cycle registered pulse, the cycle after a wrap step

## Operation
- One clock: clk.
- Reset is asynchronous and active-low. While reset=0: count=0, wrap=0, prescaler state=0.
- Priority per clk edge: clear > load > step > hold.
- clear=1: count←0, prescaler←0, wrap←0.
- load=1 (clear=0): count←load_val, prescaler←0, wrap←0.
- step = cnt_ena with prescaler out; see Configuration for the compiled-in case.
- Step up (up_dn=1):
  - count ≥ modulo: count←0 and wrap←1;
  - otherwise count←count+1.
- Step down (up_dn=0):
  - count=0: count←modulo and wrap←1;
  - otherwise count←count−1.
- No step: count holds, wrap←0.
- tc = (up_dn & count ≥ modulo) | (~up_dn & count = 0). It is independent of cnt_ena.
- Arithmetic is unsigned, WIDTH bits. Comparisons are unsigned. No carry beyond WIDTH.
- modulo=0: count stays 0, tc=1 in both directions, and every step wraps.
- modulo = 2^WIDTH−1: behaves as a plain binary wrap counter.
- load_val > modulo: the value is loaded as-is.
  - Up: next step wraps to 0.
  - Down: counts down normally through values above modulo.
- modulo or up_dn changed mid-count: takes effect on the same cycle. No state is retained.

## Timing
- count updates one clk after the qualifying edge: load/clear/step latency 1.
- wrap asserts on the edge where count takes its wrapped value. It stays high exactly one cycle unless the next cycle also wraps (e.g. modulo=0).
- tc is valid combinationally from the registered count. It has no added latency.
- Reset asserted mid-count clears immediately, asynchronously.
- Deassertion is synchronised externally. The first step can occur on the first clk edge with reset=1.
- Reset values:
  - count=0, wrap=0.
  - tc follows its equation: 1 if up_dn=0 or modulo=0.

## Configuration
- Macro: COUNTER_VAR_PRESCALE_EN.
- Defined:
  - A prescaler counter of width clog2(PRESCALE) (min 1) increments on each cnt_ena cycle.
  - step = cnt_ena & (prescaler = PRESCALE−1). The prescaler returns to 0 on that cycle.
  - Prescaler state is cleared by reset, clear and load.
  - cnt_ena=0 freezes the prescaler.
  - PRESCALE=1 is equivalent to no prescaler.
- Undefined: step = cnt_ena, the PRESCALE parameter is ignored, and no prescaler logic exists.

## Structure
- Shared package counter_pkg holds:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0 constants;
  - a clog2-safe width helper function used for the prescaler width.
- Sub-module counter_prescaler (parameter PRESCALE; ports clk, reset, ena, sclr, step).
  - Instantiated only under COUNTER_VAR_PRESCALE_EN.
- The top level holds the count register, the wrap register and the tc logic.

## Test plan
- Reset:
  - reset=0 then 1, up_dn=1, modulo=9, WIDTH=4 → count=0, wrap=0, tc=0.
  - With cnt_ena=1, count runs 1..9, then 0 with wrap=1 for one cycle.
  - tc=1 while count=9.
- Down count, modulo=5, from reset → count sequence 5,4,3,2,1,0,5.
  - wrap pulses at each 0→5 step.
  - tc=1 while count=0.
- Priority:
  - clear=1, load=1, load_val=7 together → count=0.
  - Then load=1 alone → count=7.
  - load=1 with cnt_ena=1 → count=7, no step.
- Boundary:
  - modulo=0, cnt_ena=1 → count stays 0, tc=1, wrap=1 every cycle.
  - load_val=12, modulo=9, up → next step count=0, wrap=1.
- Async reset mid-count (count=6) → count=0 immediately without a clk edge, and wrap=0.
- With COUNTER_VAR_PRESCALE_EN, PRESCALE=4, modulo=15:
  - 12 consecutive cnt_ena cycles → count=3.
  - A 2-cycle cnt_ena gap leaves the phase unchanged.
  - load resets the phase: a fresh 4 cycles are needed for the next step.
